if_fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage pipelined CPU. It consumes the hazard and branch outputs of the ID-stage control unit (`Stall`, `Pcsrc`). It owns the PC, issues requests to the instruction memory over a req/ack handshake, and presents `ID_Inst`, `ID_Pc4` and `ID_Valid` to the decoder. Redirects squash the wrong-path fetch, and a load-use stall freezes IF/ID without losing an in-flight instruction.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/if_id_reg.sv | 32 +++
 rtl/if_fetch_unit.sv | 121 ++++++++++++
 tb/tb_if_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, next-PC select encodings and the bubble word.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_e;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_id_reg
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_o  <= NOP;
      pc4_o   <= 32'h0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      inst_o  <= inst_i;
      pc4_o   <= pc4_i;
      valid_o <= 1'b1;
    end else if (bubble_i) begin
      // pc4 is meaningless for a bubble, so it is simply left as is
      inst_o  <= NOP;
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, redirect squashing and stall buffering.
module if_fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Br_target,
  input  logic [31:0] J_target,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] ID_Inst,
  output logic [31:0] ID_Pc4,
  output logic        ID_Valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  shadow_q, shadow_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redir;
  logic         id_load;
  logic         id_bubble;
  logic [31:0]  id_inst_d;

  assign pc_plus4 = pc_q + 32'd4;
  assign redir    = ID_Valid & Stall & ((Pcsrc == PCSRC_BR) | (Pcsrc == PCSRC_J));
  assign target   = ((Pcsrc == PCSRC_J) ? J_target : Br_target) & 32'hFFFF_FFFC;

  // In DISCARD the PC still holds the abandoned address, so the address stays stable until ack
  assign Imem_addr = pc_q;
  assign Imem_req  = ~Rst & (state_q != HOLD);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    shadow_d  = shadow_q;
    buf_d     = buf_q;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    id_inst_d = Imem_rdata;
    case (state_q)
      FETCH: begin
        if (redir) begin
          id_bubble = 1'b1;
          if (Imem_ack) begin
            pc_d = target;
          end else begin
            shadow_d = target;
            state_d  = DISCARD;
          end
        end else if (Imem_ack) begin
          if (Stall) begin
            id_load = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            buf_d   = Imem_rdata;
            state_d = HOLD;
          end
        end else if (Stall) begin
          id_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          id_bubble = 1'b1;
          pc_d      = target;
          state_d   = FETCH;
        end else if (Stall) begin
          id_load   = 1'b1;
          id_inst_d = buf_q;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end
      end
      DISCARD: begin
        if (redir) shadow_d = target;
        if (Imem_ack) begin
          pc_d    = redir ? target : shadow_q;
          state_d = FETCH;
        end
        if (Stall) id_bubble = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      shadow_q <= RESET_PC;
      buf_q    <= NOP;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
      buf_q    <= buf_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .load_i   (id_load),
    .bubble_i (id_bubble),
    .inst_i   (id_inst_d),
    .pc4_i    (pc_plus4),
    .inst_o   (ID_Inst),
    .pc4_o    (ID_Pc4),
    .valid_o  (ID_Valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; the memory returns 32'hC000_0000 ^ address.
module tb_if_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic [1:0]  Pcsrc;
  logic [31:0] Br_target;
  logic [31:0] J_target;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;
  logic [31:0] ID_Inst;
  logic [31:0] ID_Pc4;
  logic        ID_Valid;

  logic zw;
  logic ack_man;
  int   passed;
  int   total;

  assign Imem_ack   = zw ? Imem_req : ack_man;
  assign Imem_rdata = 32'hC000_0000 ^ Imem_addr;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Stall      (Stall),
    .Pcsrc      (Pcsrc),
    .Br_target  (Br_target),
    .J_target   (J_target),
    .Imem_req   (Imem_req),
    .Imem_addr  (Imem_addr),
    .Imem_ack   (Imem_ack),
    .Imem_rdata (Imem_rdata),
    .ID_Inst    (ID_Inst),
    .ID_Pc4     (ID_Pc4),
    .ID_Valid   (ID_Valid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    total++; if (ID_Inst !== 32'h0) $display("FAIL rst_inst: got %h want %h", ID_Inst, 32'h0); else passed++;
    total++; if (ID_Pc4 !== 32'h0) $display("FAIL rst_pc4: got %h want %h", ID_Pc4, 32'h0); else passed++;
    total++; if (ID_Valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ID_Valid); else passed++;
    total++; if (Imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", Imem_req); else passed++;
    Rst = 1'b0;
    #1;
    total++; if (Imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", Imem_req); else passed++;
    total++; if (Imem_addr !== 32'h0) $display("FAIL first_addr: got %h want %h", Imem_addr, 32'h0); else passed++;
  endtask

  task automatic test_seq();
    tick();
    total++; if (ID_Pc4 !== 32'h4) $display("FAIL seq_pc4_0: got %h want %h", ID_Pc4, 32'h4); else passed++;
    total++; if (ID_Inst !== 32'hC000_0000) $display("FAIL seq_inst_0: got %h want %h", ID_Inst, 32'hC000_0000); else passed++;
    total++; if (ID_Valid !== 1'b1) $display("FAIL seq_valid_0: got %b want 1", ID_Valid); else passed++;
    total++; if (Imem_addr !== 32'h4) $display("FAIL seq_addr_1: got %h want %h", Imem_addr, 32'h4); else passed++;
    tick();
    total++; if (ID_Pc4 !== 32'h8) $display("FAIL seq_pc4_1: got %h want %h", ID_Pc4, 32'h8); else passed++;
    total++; if (ID_Inst !== 32'hC000_0004) $display("FAIL seq_inst_1: got %h want %h", ID_Inst, 32'hC000_0004); else passed++;
    total++; if (Imem_addr !== 32'h8) $display("FAIL seq_addr_2: got %h want %h", Imem_addr, 32'h8); else passed++;
  endtask

  task automatic test_hold();
    Stall = 1'b0;
    tick();
    total++; if (Imem_req !== 1'b0) $display("FAIL hold_req_0: got %b want 0", Imem_req); else passed++;
    total++; if (ID_Inst !== 32'hC000_0004) $display("FAIL hold_inst_0: got %h want %h", ID_Inst, 32'hC000_0004); else passed++;
    tick();
    total++; if (Imem_req !== 1'b0) $display("FAIL hold_req_1: got %b want 0", Imem_req); else passed++;
    total++; if (ID_Pc4 !== 32'h8) $display("FAIL hold_pc4_1: got %h want %h", ID_Pc4, 32'h8); else passed++;
    total++; if (Imem_addr !== 32'h8) $display("FAIL hold_addr_1: got %h want %h", Imem_addr, 32'h8); else passed++;
    Stall = 1'b1;
    tick();
    total++; if (ID_Inst !== 32'hC000_0008) $display("FAIL hold_rel_inst: got %h want %h", ID_Inst, 32'hC000_0008); else passed++;
    total++; if (ID_Pc4 !== 32'hC) $display("FAIL hold_rel_pc4: got %h want %h", ID_Pc4, 32'hC); else passed++;
    total++; if (Imem_req !== 1'b1) $display("FAIL hold_rel_req: got %b want 1", Imem_req); else passed++;
    total++; if (Imem_addr !== 32'hC) $display("FAIL hold_rel_addr: got %h want %h", Imem_addr, 32'hC); else passed++;
  endtask

  task automatic test_jump();
    Pcsrc    = 2'b11;
    J_target = 32'h0000_0043;
    tick();
    total++; if (ID_Inst !== 32'h0) $display("FAIL jmp_bub_inst: got %h want %h", ID_Inst, 32'h0); else passed++;
    total++; if (ID_Valid !== 1'b0) $display("FAIL jmp_bub_valid: got %b want 0", ID_Valid); else passed++;
    total++; if (Imem_addr !== 32'h40) $display("FAIL jmp_addr: got %h want %h", Imem_addr, 32'h40); else passed++;
    Pcsrc = 2'b00;
    tick();
    total++; if (ID_Inst !== 32'hC000_0040) $display("FAIL jmp_inst: got %h want %h", ID_Inst, 32'hC000_0040); else passed++;
    total++; if (ID_Pc4 !== 32'h44) $display("FAIL jmp_pc4: got %h want %h", ID_Pc4, 32'h44); else passed++;
    total++; if (ID_Valid !== 1'b1) $display("FAIL jmp_valid: got %b want 1", ID_Valid); else passed++;
  endtask

  task automatic test_stall_no_redir();
    Stall     = 1'b0;
    Pcsrc     = 2'b01;
    Br_target = 32'h0000_0200;
    tick();
    total++; if (Imem_addr !== 32'h44) $display("FAIL snr_addr: got %h want %h", Imem_addr, 32'h44); else passed++;
    total++; if (ID_Inst !== 32'hC000_0040) $display("FAIL snr_inst: got %h want %h", ID_Inst, 32'hC000_0040); else passed++;
    total++; if (ID_Valid !== 1'b1) $display("FAIL snr_valid: got %b want 1", ID_Valid); else passed++;
    Pcsrc = 2'b00;
    Stall = 1'b1;
    tick();
    total++; if (ID_Inst !== 32'hC000_0044) $display("FAIL snr_rel_inst: got %h want %h", ID_Inst, 32'hC000_0044); else passed++;
    total++; if (Imem_addr !== 32'h48) $display("FAIL snr_rel_addr: got %h want %h", Imem_addr, 32'h48); else passed++;
  endtask

  task automatic test_wrap();
    Pcsrc    = 2'b11;
    J_target = 32'hFFFF_FFFF;
    tick();
    total++; if (Imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want %h", Imem_addr, 32'hFFFF_FFFC); else passed++;
    Pcsrc = 2'b00;
    tick();
    total++; if (ID_Inst !== 32'h3FFF_FFFC) $display("FAIL wrap_inst: got %h want %h", ID_Inst, 32'h3FFF_FFFC); else passed++;
    total++; if (ID_Pc4 !== 32'h0) $display("FAIL wrap_pc4: got %h want %h", ID_Pc4, 32'h0); else passed++;
    total++; if (Imem_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want %h", Imem_addr, 32'h0); else passed++;
  endtask

  task automatic test_branch_latency();
    Pcsrc    = 2'b11;
    J_target = 32'h0000_000C;
    tick();
    Pcsrc = 2'b00;
    tick();
    total++; if (ID_Pc4 !== 32'h10) $display("FAIL lat_setup_pc4: got %h want %h", ID_Pc4, 32'h10); else passed++;
    zw        = 1'b0;
    ack_man   = 1'b0;
    Pcsrc     = 2'b01;
    Br_target = 32'h0000_0100;
    tick();
    total++; if (ID_Valid !== 1'b0) $display("FAIL lat_bub0_valid: got %b want 0", ID_Valid); else passed++;
    total++; if (ID_Inst !== 32'h0) $display("FAIL lat_bub0_inst: got %h want %h", ID_Inst, 32'h0); else passed++;
    total++; if (Imem_addr !== 32'h10) $display("FAIL lat_addr_0: got %h want %h", Imem_addr, 32'h10); else passed++;
    total++; if (Imem_req !== 1'b1) $display("FAIL lat_req_0: got %b want 1", Imem_req); else passed++;
    Pcsrc = 2'b00;
    tick();
    total++; if (Imem_addr !== 32'h10) $display("FAIL lat_addr_1: got %h want %h", Imem_addr, 32'h10); else passed++;
    total++; if (ID_Valid !== 1'b0) $display("FAIL lat_bub1_valid: got %b want 0", ID_Valid); else passed++;
    ack_man = 1'b1;
    tick();
    total++; if (Imem_addr !== 32'h100) $display("FAIL lat_addr_2: got %h want %h", Imem_addr, 32'h100); else passed++;
    total++; if (ID_Valid !== 1'b0) $display("FAIL lat_bub2_valid: got %b want 0", ID_Valid); else passed++;
    total++; if (ID_Inst !== 32'h0) $display("FAIL lat_bub2_inst: got %h want %h", ID_Inst, 32'h0); else passed++;
    ack_man = 1'b0;
    zw      = 1'b1;
    tick();
    total++; if (ID_Inst !== 32'hC000_0100) $display("FAIL lat_inst: got %h want %h", ID_Inst, 32'hC000_0100); else passed++;
    total++; if (ID_Pc4 !== 32'h104) $display("FAIL lat_pc4: got %h want %h", ID_Pc4, 32'h104); else passed++;
  endtask

  task automatic test_reset_mid();
    zw      = 1'b0;
    ack_man = 1'b0;
    tick();
    total++; if (Imem_addr !== 32'h104) $display("FAIL rm_pend_addr: got %h want %h", Imem_addr, 32'h104); else passed++;
    Rst = 1'b1;
    #1;
    total++; if (Imem_req !== 1'b0) $display("FAIL rm_req: got %b want 0", Imem_req); else passed++;
    total++; if (Imem_addr !== 32'h0) $display("FAIL rm_addr: got %h want %h", Imem_addr, 32'h0); else passed++;
    total++; if (ID_Pc4 !== 32'h0) $display("FAIL rm_pc4: got %h want %h", ID_Pc4, 32'h0); else passed++;
    total++; if (ID_Inst !== 32'h0) $display("FAIL rm_inst: got %h want %h", ID_Inst, 32'h0); else passed++;
    ack_man = 1'b1;
    tick();
    total++; if (ID_Valid !== 1'b0) $display("FAIL rm_late_ack: got %b want 0", ID_Valid); else passed++;
    Rst     = 1'b0;
    ack_man = 1'b0;
    zw      = 1'b1;
    #1;
    total++; if (Imem_req !== 1'b1) $display("FAIL rm_restart_req: got %b want 1", Imem_req); else passed++;
    total++; if (Imem_addr !== 32'h0) $display("FAIL rm_restart_addr: got %h want %h", Imem_addr, 32'h0); else passed++;
    tick();
    total++; if (ID_Inst !== 32'hC000_0000) $display("FAIL rm_restart_inst: got %h want %h", ID_Inst, 32'hC000_0000); else passed++;
    total++; if (ID_Pc4 !== 32'h4) $display("FAIL rm_restart_pc4: got %h want %h", ID_Pc4, 32'h4); else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    Rst       = 1'b1;
    Stall     = 1'b1;
    Pcsrc     = 2'b00;
    Br_target = 32'h0;
    J_target  = 32'h0;
    zw        = 1'b1;
    ack_man   = 1'b0;
    test_reset();
    test_seq();
    test_hold();
    test_jump();
    test_stall_no_redir();
    test_wrap();
    test_branch_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
